ws2812_frame_ctrl: RTL
======================

Name: ws2812_frame_ctrl

Overview:
Double-buffered pixel-memory controller for one WS2812 strip driver. Host writes pixels into the back bank of an external dual-port pixel RAM (2 x 2^ADDR_W x 24 bit). The driver reads only the front bank. Banks swap only at a frame boundary, so the strip never shows a torn frame. Also sequences a back-bank clear, and counts displayed frames.

Parameters:
LED_COUNT, 300, number of pixels on the strip; valid pixel addresses are 0..LED_COUNT-1
ADDR_W, 9, pixel address width; LED_COUNT <= 2^ADDR_W

Ports:
clk_i  in  1  system clock
rst_n_i  in  1  asynchronous active-low reset
wr_valid_i  in  1  host pixel write request
wr_ready_o  out  1  controller accepts the write this cycle
wr_addr_i  in  ADDR_W  host pixel address
wr_data_i  in  24  host pixel {r,g,b}
commit_i  in  1  pulse: present the back bank at the next frame boundary
clear_i  in  1  pulse: zero-fill the back bank
drv_addr_i  in  ADDR_W  driver pixel read address
frame_sync_i  in  1  one-cycle driver frame-end strobe (start of reset symbol)
ram_raddr_o  out  ADDR_W+1  {front_bank, drv_addr_i}, combinational
ram_we_o  out  1  RAM write enable
ram_waddr_o  out  ADDR_W+1  {back_bank, pixel address}
ram_wdata_o  out  24  RAM write data
front_bank_o  out  1  bank currently displayed
busy_o  out  1  high in CLEAR or PENDING
addr_err_o  out  1  sticky: an out-of-range write was dropped
frame_count_o  out  16  frame_sync_i count, wraps 0xFFFF->0

Behaviour:
- Reset (async assert, sync release) drives these values:
  - State IDLE; front_bank=0, so back_bank=1.
  - wr_ready_o=0 while reset is asserted.
  - ram_we_o=0, ram_waddr_o=0, ram_wdata_o=0.
  - addr_err_o=0, frame_count_o=0, busy_o=0.
  - Clear and commit latches cleared.
- back_bank is always the inverse of front_bank.
- ram_raddr_o is combinational. It carries no latency and is not affected by state.
- Write path:
  - Handshake: a write transfers when wr_valid_i and wr_ready_o are both high on a rising edge.
  - wr_ready_o=1 only in IDLE. It is a registered output, low in all other states.
  - Write port is registered. An accepted write at edge N drives ram_we_o=1 for exactly the cycle after N, with ram_waddr_o={back_bank, wr_addr_i} and ram_wdata_o=wr_data_i.
  - If wr_addr_i >= LED_COUNT: the handshake still completes, no RAM write is made (ram_we_o stays 0), and addr_err_o is set. addr_err_o clears only on reset.
- States:
  - IDLE: accept writes.
    - clear_i -> CLEAR (clear has priority over commit).
    - commit_i -> PENDING.
    - If clear_i and commit_i are both high: go to CLEAR with commit latched. After the clear, go to PENDING.
    - A write accepted in the same cycle as commit_i is included in the committed frame.
  - CLEAR: counter runs 0..LED_COUNT-1.
    - Writes zeros to {back_bank, cnt}, one per cycle, so ram_we_o=1 for LED_COUNT consecutive cycles.
    - After the final word: go to PENDING if commit is latched, else IDLE.
    - commit_i seen during CLEAR is latched. clear_i during CLEAR is ignored.
  - PENDING: wait for frame_sync_i.
    - frame_sync_i=1: toggle front_bank on that edge, go to IDLE.
    - The new front bank is visible on ram_raddr_o the next cycle.
    - A frame_sync_i arriving on the same edge that enters PENDING is not used; the swap happens at the following sync.
    - commit_i and clear_i are ignored in PENDING.
- The registered final write always lands before a swap, because PENDING lasts at least one cycle.
- frame_count_o increments on every frame_sync_i, in every state.
- Reset asserted mid-CLEAR or mid-PENDING: abort immediately to the reset values. The partially written bank is not retried.

Test Plan:
- Reset release, LED_COUNT=4 -> front_bank_o=0, wr_ready_o=1 one cycle after release, ram_raddr_o={0, drv_addr_i}.
- Write addr 2, data 0x112233 -> ram_we_o=1 the next cycle, ram_waddr_o=0x202 (bank 1, addr 2), data 0x112233; no other ram_we_o pulses.
- Write addr 7 (LED_COUNT=4) -> handshake completes, ram_we_o stays 0, addr_err_o=1 until reset.
- commit_i then frame_sync_i 5 cycles later -> busy_o high and wr_ready_o=0 for those cycles; front_bank_o toggles to 1 on the sync edge; ram_raddr_o MSB=1 the next cycle; IDLE resumes.
- clear_i and commit_i in the same cycle, LED_COUNT=4 -> 4 consecutive zero writes to bank 1 (addrs 0..3), then PENDING; swap at the next sync.
- frame_sync_i on the same edge as commit_i -> no swap; swap at the second sync. frame_count_o=2 after both syncs.
- Reset asserted mid-CLEAR -> ram_we_o=0 and state IDLE immediately; front_bank_o=0.

Source files
------------

// File: rtl/ws2812_frame_ctrl.sv
// Double-buffered pixel-memory controller for a WS2812 strip driver.
// The host fills the back bank; banks swap only on a driver frame boundary.
module ws2812_frame_ctrl #(
    parameter int LED_COUNT = 300,
    parameter int ADDR_W    = 9
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              wr_valid_i,
    output logic              wr_ready_o,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [23:0]       wr_data_i,
    input  logic              commit_i,
    input  logic              clear_i,
    input  logic [ADDR_W-1:0] drv_addr_i,
    input  logic              frame_sync_i,
    output logic [ADDR_W:0]   ram_raddr_o,
    output logic              ram_we_o,
    output logic [ADDR_W:0]   ram_waddr_o,
    output logic [23:0]       ram_wdata_o,
    output logic              front_bank_o,
    output logic              busy_o,
    output logic              addr_err_o,
    output logic [15:0]       frame_count_o
);

    // state   | meaning
    // IDLE    | host writes accepted into the back bank
    // CLEAR   | zero-filling the back bank, one word per cycle
    // PENDING | back bank committed, waiting for frame_sync_i to swap
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CLEAR   = 2'd1,
        ST_PENDING = 2'd2
    } state_t;

    localparam logic [ADDR_W:0]   LED_CNT  = (ADDR_W+1)'(LED_COUNT);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(LED_COUNT - 1);

    state_t            state;
    logic [ADDR_W-1:0] clr_cnt;
    logic              commit_pend;
    logic              back_bank;
    logic              wr_accept;
    logic              wr_in_range;

    assign back_bank   = ~front_bank_o;
    assign ram_raddr_o = {front_bank_o, drv_addr_i};
    assign wr_accept   = wr_valid_i & wr_ready_o;
    assign wr_in_range = ({1'b0, wr_addr_i} < LED_CNT);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state         <= ST_IDLE;
            clr_cnt       <= '0;
            commit_pend   <= 1'b0;
            front_bank_o  <= 1'b0;
            wr_ready_o    <= 1'b0;
            busy_o        <= 1'b0;
            ram_we_o      <= 1'b0;
            ram_waddr_o   <= '0;
            ram_wdata_o   <= '0;
            addr_err_o    <= 1'b0;
            frame_count_o <= '0;
        end else begin
            ram_we_o <= 1'b0;
            if (frame_sync_i) begin
                frame_count_o <= frame_count_o + 16'd1;
            end

            case (state)
                ST_IDLE: begin
                    if (wr_accept) begin
                        if (wr_in_range) begin
                            ram_we_o    <= 1'b1;
                            ram_waddr_o <= {back_bank, wr_addr_i};
                            ram_wdata_o <= wr_data_i;
                        end else begin
                            addr_err_o <= 1'b1;
                        end
                    end
                    // Clear wins; a simultaneous commit is held until the fill ends.
                    if (clear_i) begin
                        state       <= ST_CLEAR;
                        clr_cnt     <= '0;
                        commit_pend <= commit_i;
                        busy_o      <= 1'b1;
                        wr_ready_o  <= 1'b0;
                    end else if (commit_i) begin
                        state      <= ST_PENDING;
                        busy_o     <= 1'b1;
                        wr_ready_o <= 1'b0;
                    end else begin
                        wr_ready_o <= 1'b1;
                    end
                end

                ST_CLEAR: begin
                    ram_we_o    <= 1'b1;
                    ram_waddr_o <= {back_bank, clr_cnt};
                    ram_wdata_o <= '0;
                    if (clr_cnt == LAST_IDX) begin
                        commit_pend <= 1'b0;
                        if (commit_pend || commit_i) begin
                            state <= ST_PENDING;
                        end else begin
                            state      <= ST_IDLE;
                            busy_o     <= 1'b0;
                            wr_ready_o <= 1'b1;
                        end
                    end else begin
                        clr_cnt     <= clr_cnt + ADDR_W'(1);
                        commit_pend <= commit_pend | commit_i;
                    end
                end

                ST_PENDING: begin
                    if (frame_sync_i) begin
                        front_bank_o <= ~front_bank_o;
                        state        <= ST_IDLE;
                        busy_o       <= 1'b0;
                        wr_ready_o   <= 1'b1;
                    end
                end

                default: begin
                    state      <= ST_IDLE;
                    busy_o     <= 1'b0;
                    wr_ready_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
